// File: rtl/fetch_unit_pkg.sv
// ------------------------------------------------------------------
// fetch_unit_pkg : shared fetch state encoding and PC step
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int unsigned c_PC_INC = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ------------------------------------------------------------------
// fetch_unit_if : instruction memory req/ack bus
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

`default_nettype wire

// File: rtl/fetch_skid.sv
// ------------------------------------------------------------------
// fetch_skid : one-entry {inst, pc} holding buffer with flush
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic                  i_clock,
  input  wire logic                  i_reset,
  input  wire logic                  i_flush,
  input  wire logic                  i_push,
  input  wire logic                  i_pop,
  input  wire logic [DATA_WIDTH-1:0] i_inst,
  input  wire logic [ADDR_WIDTH-1:0] i_pc,
  output logic                       o_full,
  output logic      [DATA_WIDTH-1:0] o_inst,
  output logic      [ADDR_WIDTH-1:0] o_pc
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [ADDR_WIDTH-1:0] r_pc;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_full <= 1'b0;
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ------------------------------------------------------------------
// fetch_unit : PC, instruction memory requests, skid-buffered output
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  wire logic                  i_clock,
  input  wire logic                  i_reset,
  input  wire logic                  i_redirect,
  input  wire logic [ADDR_WIDTH-1:0] i_target,
  input  wire logic                  i_stall,
  fetch_unit_if.master               mem,
  output logic                       o_valid,
  output logic      [DATA_WIDTH-1:0] o_inst,
  output logic      [ADDR_WIDTH-1:0] o_pc,
  output logic                       o_fault
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] r_drain_addr;
  logic [ADDR_WIDTH-1:0] w_drain_nxt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [ADDR_WIDTH-1:0] r_opc;

  logic                  w_consume;
  logic                  w_clr_valid;
  logic                  w_load_mem;
  logic                  w_load_skid;
  logic                  w_skid_push;
  logic                  w_skid_pop;
  logic                  w_skid_flush;
  logic                  w_skid_full;
  logic [DATA_WIDTH-1:0] w_skid_inst;
  logic [ADDR_WIDTH-1:0] w_skid_pc;

  assign w_consume = r_valid & ~i_stall;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_drain_nxt  = r_drain_addr;
    w_clr_valid  = 1'b0;
    w_load_mem   = 1'b0;
    w_load_skid  = 1'b0;
    w_skid_push  = 1'b0;
    w_skid_pop   = 1'b0;
    w_skid_flush = 1'b0;

    if (i_redirect) begin
      w_skid_flush = 1'b1;
      w_clr_valid  = 1'b1;
      w_pc_nxt     = i_target;
      if (i_target[1:0] != 2'b00) begin
        w_state_nxt = ST_FAULT;
      end else if (r_state == ST_FETCH && !mem.ack) begin
        // The in-flight request cannot be withdrawn; remember its address.
        w_state_nxt = ST_DRAIN;
        w_drain_nxt = r_pc;
      end else if (r_state == ST_DRAIN && !mem.ack) begin
        w_state_nxt = ST_DRAIN;
      end else begin
        w_state_nxt = ST_FETCH;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (mem.ack) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(c_PC_INC);
            if (!r_valid || w_consume) begin
              w_load_mem = 1'b1;
            end else begin
              w_skid_push = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end else if (w_consume) begin
            w_clr_valid = 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_consume && w_skid_full) begin
            w_skid_pop  = 1'b1;
            w_load_skid = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (mem.ack) begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc         <= RESET_VECTOR;
      r_drain_addr <= '0;
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_opc        <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_nxt;
      if (w_clr_valid) begin
        r_valid <= 1'b0;
      end else if (w_load_mem) begin
        r_valid <= 1'b1;
        r_inst  <= mem.rdata;
        r_opc   <= r_pc;
      end else if (w_load_skid) begin
        r_valid <= 1'b1;
        r_inst  <= w_skid_inst;
        r_opc   <= w_skid_pc;
      end
    end
  end

  fetch_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (w_skid_flush),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_inst  (mem.rdata),
    .i_pc    (r_pc),
    .o_full  (w_skid_full),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  assign mem.req  = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign mem.addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign o_valid  = r_valid;
  assign o_inst   = r_inst;
  assign o_pc     = r_opc;
  assign o_fault  = (r_state == ST_FAULT);

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end of the RISC-V core. Holds the program counter and issues word requests to instruction memory with a req/ack handshake. Presents fetched instructions to decode through a valid/stall interface with a one-entry skid buffer. Its redirect target comes from the next-PC 2:1 selector (branch/jump target vs. sequential), so this block sits directly downstream of that mux.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / memory address width
- RESET_VECTOR, 0, first fetch address after reset; must be word-aligned
- i_clock  in  1  clock, rising edge
- i_reset  in  1  one clock; reset is asynchronous and active-low
- i_redirect  in  1  load PC from i_target this cycle and flush fetched instructions
- i_target  in  ADDR_WIDTH  redirect address, from the next-PC selector
- i_stall  in  1  decode cannot accept o_inst this cycle
- o_mem_req  out  1  memory request valid
- o_mem_addr  out  ADDR_WIDTH  request address, word-aligned
- i_mem_ack  in  1  request accepted; i_mem_rdata valid in the same cycle
- i_mem_rdata  in  DATA_WIDTH  instruction word
- o_valid  out  1  o_inst / o_pc hold an instruction
- o_inst  out  DATA_WIDTH  instruction
- o_pc  out  ADDR_WIDTH  address of o_inst
- o_fault  out  1  misaligned redirect target seen

## Operation
- States:
  - IDLE: one cycle after reset.
  - FETCH: o_mem_req=1.
  - WAIT: skid full, no request.
  - DRAIN: stale request outstanding after a redirect.
  - FAULT
- Reset values: state IDLE, pc=RESET_VECTOR, o_mem_req=0, o_valid=0, skid empty, o_fault=0, o_inst=0, o_pc=0.
- IDLE → FETCH unconditionally.
- FETCH:
  - o_mem_addr=pc. o_mem_req and o_mem_addr stay stable until ack.
  - On ack: {rdata, pc} goes to the output register if it is free (!o_valid, or consumed this cycle); otherwise it goes to the skid. pc += 4.
  - If the skid becomes full, go to WAIT; else stay in FETCH.
- WAIT: when the output is consumed, skid moves to output, then return to FETCH.
- Consumption: an edge with o_valid && !i_stall. If the skid is full, the skid moves to output; otherwise o_valid clears unless new data arrives that cycle.
- Redirect (highest priority, any state except during reset):
  - Clear o_valid and the skid; pc=i_target.
  - If i_target[1:0]≠0: go to FAULT, set o_fault=1.
  - Else if in FETCH without ack this cycle: go to DRAIN (the request stays held at the old address until ack; its data is discarded).
  - Otherwise go to FETCH at i_target.
- DRAIN:
  - On ack, discard data and go to FETCH at pc.
  - A further redirect in DRAIN only updates pc.
- FAULT:
  - No requests. o_fault held.
  - Only an aligned redirect (→ FETCH, o_fault clears) or reset exits.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 wraps to 0 silently.
- Reset asserted mid-request: all state returns to reset values immediately; the memory side must tolerate an abandoned request.

## Timing
- First o_mem_req=1 appears in the first cycle after the first edge following reset release, with address RESET_VECTOR.
- Latency: ack in cycle N → o_valid=1 in cycle N+1.
- Throughput: with ack tied high and no stall, one instruction per cycle.
- Redirect in cycle N (no pending request): o_mem_addr=i_target in cycle N+1; o_valid=0 in N+1.
- o_fault rises in the cycle after the redirect.
- Redirect and consumption in the same cycle: the redirect wins and the instruction is dropped.

## Structure
- Shared package (core package): state enum (IDLE, FETCH, WAIT, DRAIN, FAULT) and the PC increment constant 4.
- Sub-module: fetch_skid, a one-entry {inst, pc} buffer with a flush input. All other logic is inline.

## Test plan
- Reset release, ack tied 1, no stall → o_mem_addr sequence 0,4,8,…; o_valid from cycle 2 onward; o_pc/o_inst match the memory model.
- Stall held 3 cycles with ack=1 → one word goes to the skid, o_mem_req drops; on release, o_inst follows in order with no loss or duplication.
- Redirect to 0x100 while a request at 0x8 waits 2 cycles for ack → o_mem_addr held at 0x8 until ack; that data is never presented; next request is 0x100.
- Redirect to 0x102 → o_fault=1, o_mem_req=0 for 5 cycles; then redirect to 0x200 → o_fault=0, fetch resumes at 0x200.
- RESET_VECTOR=0xFFFFFFF8, ack=1 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Reset asserted while o_mem_req=1 and the skid is full → all outputs go to reset values in the same cycle, asynchronously.
